// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter: two requesters share one 3-bit signed 7-segment display value.
// Latency: grant, value latch and gnt pulse all appear one cycle after the request is sampled.
// Backpressure: none. A grant holds the display for HOLD cycles; requests arriving during a hold wait for re-arbitration.
module seg_display_arbiter #(
    parameter int unsigned HOLD = 8
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       req_a,
    input  logic [2:0] val_a,
    input  logic       req_b,
    input  logic [2:0] val_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [2:0] disp_value,
    output logic       disp_valid,
    output logic       disp_owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    // Reload value for the hold counter; HOLD cycles of display means HOLD-1 down to 0.
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;          // 0 = A has priority on a tie, 1 = B
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       owner_q, owner_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;

    logic       rearb;
    logic       any_req;
    logic       win_b;

    // Arbitration happens from IDLE, or on the last cycle of a hold so grants run back-to-back.
    assign rearb   = (state_q == IDLE) || (cnt_q == 8'd0);
    assign any_req = req_a | req_b;
    // A lone requester always wins; on a tie the pointer decides.
    assign win_b   = req_b & (~req_a | ptr_q);

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = valid_q;
        owner_d = owner_q;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        if (rearb) begin
            if (any_req) begin
                state_d = win_b ? SHOW_B : SHOW_A;
                value_d = win_b ? val_b : val_a;
                valid_d = 1'b1;
                owner_d = win_b;
                cnt_d   = HOLD_M1;
                ptr_d   = ~win_b;
                gnt_a_d = ~win_b;
                gnt_b_d = win_b;
            end else begin
                state_d = IDLE;
                value_d = 3'b000;
                valid_d = 1'b0;
                owner_d = 1'b0;
                cnt_d   = 8'd0;
            end
        end else begin
            // Not re-arbitrating implies cnt_q is non-zero, so this never wraps.
            cnt_d = cnt_q - 8'd1;
        end
    end

    // State and registered outputs; reset aborts any hold without a pulse.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 8'd0;
            value_q <= 3'b000;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign disp_value = value_q;
    assign disp_valid = valid_q;
    assign disp_owner = owner_q;

    // Counter stays within its load range, i.e. never underflows past zero.
    a_cnt_range: assert property (@(posedge clk_2) disable iff (!reset) cnt_q <= HOLD_M1);
    // Grant pulses are mutually exclusive.
    a_gnt_onehot: assert property (@(posedge clk_2) disable iff (!reset) !(gnt_a_q && gnt_b_q));
    // Display validity tracks the FSM state.
    a_valid_state: assert property (@(posedge clk_2) disable iff (!reset) valid_q == (state_q != IDLE));

endmodule
